id_ex_stage: RTL and testbench

Decode-to-execute pipeline register of the pipelined MIPS core; sits directly upstream of the ALU and produces its operand and opcode/func/sa inputs. Each cycle it captures one decoded instruction and selects operands from the register file or the forwarding paths. It detects load-use hazards, stalls decode and inserts bubbles. It also kills its contents on a taken branch or jump.

---
 rtl/id_ex_stage_if.sv | 29 ++
 rtl/id_ex_stage.sv | 259 +++++++++++++++++++++++++
 tb/tb_id_ex_stage.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// ---------------------------------------------------------------------------
// id_ex_stage_if
// Decode-to-execute handshake bundle: decode offers one instruction plus its
// register-file read data, the ID/EX stage answers with id_ready.
//   id_valid   decode -> stage   instruction present
//   id_ready   stage  -> decode  instruction accepted this cycle
//   id_instr   decode -> stage   raw 32-bit MIPS instruction
//   id_rs_val  decode -> stage   register-file data for rs
//   id_rt_val  decode -> stage   register-file data for rt
// ---------------------------------------------------------------------------
interface id_ex_stage_if #(
  parameter int DATA_W = 32
);
  logic              id_valid;
  logic              id_ready;
  logic [31:0]       id_instr;
  logic [DATA_W-1:0] id_rs_val;
  logic [DATA_W-1:0] id_rt_val;

  modport master (
    output id_valid, id_instr, id_rs_val, id_rt_val,
    input  id_ready
  );

  modport slave (
    input  id_valid, id_instr, id_rs_val, id_rt_val,
    output id_ready
  );
endinterface

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register of the pipelined MIPS core. Decodes the incoming
// instruction, picks forwarded operands, detects load-use hazards (stalling
// decode and inserting bubbles) and kills its contents on a taken branch.
//   clk, rst_n          clock, asynchronous active-low reset
//   id_bus (slave)      decode handshake, instruction, register-file data
//   flush               taken branch / jump: load a bubble
//   exm_*               EX/MEM forward source and load indication
//   wb_*                MEM/WB forward source
//   ex_*                registered ALU operands, opcode/func/sa, control
//   stall_cnt           saturating count of stall cycles
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  id_ex_stage_if.slave      id_bus,
  input  logic              flush,
  input  logic              exm_wr_en,
  input  logic              exm_mem_read,
  input  logic [4:0]        exm_wr_addr,
  input  logic [DATA_W-1:0] exm_wr_data,
  input  logic              wb_wr_en,
  input  logic [4:0]        wb_wr_addr,
  input  logic [DATA_W-1:0] wb_wr_data,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_first_val,
  output logic [DATA_W-1:0] ex_second_val,
  output logic [5:0]        ex_opcode,
  output logic [5:0]        ex_func,
  output logic [4:0]        ex_sa,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [4:0]        ex_dest,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic [15:0]       stall_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] FN_JR    = 6'b001000;

  // Instruction fields
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd, sa;
  logic [5:0]  func;
  logic [15:0] imm;

  assign opcode = id_bus.id_instr[31:26];
  assign rs     = id_bus.id_instr[25:21];
  assign rt     = id_bus.id_instr[20:16];
  assign rd     = id_bus.id_instr[15:11];
  assign sa     = id_bus.id_instr[10:6];
  assign func   = id_bus.id_instr[5:0];
  assign imm    = id_bus.id_instr[15:0];

  // Registered state
  logic              ex_valid_q,      ex_valid_d;
  logic [DATA_W-1:0] ex_first_val_q,  ex_first_val_d;
  logic [DATA_W-1:0] ex_second_val_q, ex_second_val_d;
  logic [5:0]        ex_opcode_q,     ex_opcode_d;
  logic [5:0]        ex_func_q,       ex_func_d;
  logic [4:0]        ex_sa_q,         ex_sa_d;
  logic [DATA_W-1:0] ex_store_data_q, ex_store_data_d;
  logic [4:0]        ex_dest_q,       ex_dest_d;
  logic              ex_reg_write_q,  ex_reg_write_d;
  logic              ex_mem_read_q,   ex_mem_read_d;
  logic              ex_mem_write_q,  ex_mem_write_d;
  logic [15:0]       stall_cnt_q,     stall_cnt_d;

  // Source usage: index 0 = rs, index 1 = rt
  logic              is_jump;
  logic              src_used [2];
  logic [4:0]        src_addr [2];
  logic [DATA_W-1:0] src_rf   [2];
  logic [DATA_W-1:0] src_val  [2];
  logic [1:0]        src_haz;
  logic              stall;

  assign is_jump     = (opcode[5:1] == 5'b00001);
  assign src_used[0] = !is_jump;
  assign src_used[1] = (opcode == OP_RTYPE) || (opcode == OP_BEQ) ||
                       (opcode == OP_BNE)   || (opcode == OP_SW);
  assign src_addr[0] = rs;
  assign src_addr[1] = rt;
  assign src_rf[0]   = id_bus.id_rs_val;
  assign src_rf[1]   = id_bus.id_rt_val;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      // Priority forwarding mux; $0 is hard-wired so writes to it never forward.
      always_comb begin
        src_val[gi] = src_rf[gi];
        if (src_addr[gi] == 5'd0)
          src_val[gi] = '0;
        else if (exm_wr_en && (exm_wr_addr == src_addr[gi]))
          src_val[gi] = exm_wr_data;
        else if (wb_wr_en && (wb_wr_addr == src_addr[gi]))
          src_val[gi] = wb_wr_data;
      end

      // A load in EX (distance 1) or in EX/MEM (distance 2) whose data is not
      // yet available to the forwarding muxes.
      assign src_haz[gi] = src_used[gi] && (src_addr[gi] != 5'd0) &&
                           ((ex_valid_q && ex_mem_read_q && (ex_dest_q == src_addr[gi])) ||
                            (exm_mem_read && exm_wr_en && (exm_wr_addr == src_addr[gi])));
    end
  endgenerate

  assign stall           = id_bus.id_valid && !flush && (|src_haz);
  assign id_bus.id_ready = !stall;

  // Decode of the presented instruction
  logic              dec_known;
  logic [DATA_W-1:0] dec_first, dec_second, dec_store;
  logic [5:0]        dec_func;
  logic [4:0]        dec_sa, dec_dest;
  logic              dec_rw, dec_mr, dec_mw;

  always_comb begin
    dec_known  = 1'b1;
    dec_first  = src_val[0];
    dec_second = '0;
    dec_store  = '0;
    dec_func   = '0;
    dec_sa     = '0;
    dec_dest   = '0;
    dec_rw     = 1'b0;
    dec_mr     = 1'b0;
    dec_mw     = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dec_second = src_val[1];
        dec_func   = func;
        dec_sa     = sa;
        dec_dest   = rd;
        dec_rw     = (rd != 5'd0) && (func != FN_JR);
      end
      OP_ADDI, OP_ADDIU: begin
        dec_second = {{(DATA_W-16){imm[15]}}, imm};
        dec_dest   = rt;
        dec_rw     = (rt != 5'd0);
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        dec_second = {{(DATA_W-16){1'b0}}, imm};
        dec_dest   = rt;
        dec_rw     = (rt != 5'd0);
      end
      OP_LW: begin
        dec_second = {{(DATA_W-16){imm[15]}}, imm};
        dec_dest   = rt;
        dec_mr     = 1'b1;
        dec_rw     = (rt != 5'd0);
      end
      OP_SW: begin
        dec_second = {{(DATA_W-16){imm[15]}}, imm};
        dec_store  = src_val[1];
        dec_mw     = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        dec_second = src_val[1];
      end
      default: begin
        // Jumps carry zero operands; unknown opcodes travel as a valid bubble.
        dec_first = '0;
        dec_known = is_jump;
      end
    endcase
  end

  // Next-state selection: flush beats stall beats capture
  always_comb begin
    ex_valid_d      = 1'b0;
    ex_first_val_d  = '0;
    ex_second_val_d = '0;
    ex_opcode_d     = '0;
    ex_func_d       = '0;
    ex_sa_d         = '0;
    ex_store_data_d = '0;
    ex_dest_d       = '0;
    ex_reg_write_d  = 1'b0;
    ex_mem_read_d   = 1'b0;
    ex_mem_write_d  = 1'b0;
    stall_cnt_d     = stall_cnt_q;
    if (stall) begin
      if (stall_cnt_q != 16'hFFFF)
        stall_cnt_d = stall_cnt_q + 16'd1;
    end else if (id_bus.id_valid && !flush) begin
      ex_valid_d = 1'b1;
      if (dec_known) begin
        ex_first_val_d  = dec_first;
        ex_second_val_d = dec_second;
        ex_opcode_d     = opcode;
        ex_func_d       = dec_func;
        ex_sa_d         = dec_sa;
        ex_store_data_d = dec_store;
        ex_dest_d       = dec_dest;
        ex_reg_write_d  = dec_rw;
        ex_mem_read_d   = dec_mr;
        ex_mem_write_d  = dec_mw;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q      <= 1'b0;
      ex_first_val_q  <= '0;
      ex_second_val_q <= '0;
      ex_opcode_q     <= '0;
      ex_func_q       <= '0;
      ex_sa_q         <= '0;
      ex_store_data_q <= '0;
      ex_dest_q       <= '0;
      ex_reg_write_q  <= 1'b0;
      ex_mem_read_q   <= 1'b0;
      ex_mem_write_q  <= 1'b0;
      stall_cnt_q     <= '0;
    end else begin
      ex_valid_q      <= ex_valid_d;
      ex_first_val_q  <= ex_first_val_d;
      ex_second_val_q <= ex_second_val_d;
      ex_opcode_q     <= ex_opcode_d;
      ex_func_q       <= ex_func_d;
      ex_sa_q         <= ex_sa_d;
      ex_store_data_q <= ex_store_data_d;
      ex_dest_q       <= ex_dest_d;
      ex_reg_write_q  <= ex_reg_write_d;
      ex_mem_read_q   <= ex_mem_read_d;
      ex_mem_write_q  <= ex_mem_write_d;
      stall_cnt_q     <= stall_cnt_d;
    end
  end

  assign ex_valid      = ex_valid_q;
  assign ex_first_val  = ex_first_val_q;
  assign ex_second_val = ex_second_val_q;
  assign ex_opcode     = ex_opcode_q;
  assign ex_func       = ex_func_q;
  assign ex_sa         = ex_sa_q;
  assign ex_store_data = ex_store_data_q;
  assign ex_dest       = ex_dest_q;
  assign ex_reg_write  = ex_reg_write_q;
  assign ex_mem_read   = ex_mem_read_q;
  assign ex_mem_write  = ex_mem_write_q;
  assign stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
// Directed bench for id_ex_stage. Each step drives decode/forward inputs,
// pushes the expected EX register contents to a queue, and after the next
// rising edge pops and compares them against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_ex_stage_if #(.DATA_W(32)) dif ();

  logic        flush, exm_wr_en, exm_mem_read, wb_wr_en;
  logic [4:0]  exm_wr_addr, wb_wr_addr;
  logic [31:0] exm_wr_data, wb_wr_data;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [31:0] ex_first_val, ex_second_val, ex_store_data;
  logic [5:0]  ex_opcode, ex_func;
  logic [4:0]  ex_sa, ex_dest;
  logic [15:0] stall_cnt;

  id_ex_stage #(.DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .id_bus(dif.slave), .flush(flush),
    .exm_wr_en(exm_wr_en), .exm_mem_read(exm_mem_read),
    .exm_wr_addr(exm_wr_addr), .exm_wr_data(exm_wr_data),
    .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data),
    .ex_valid(ex_valid), .ex_first_val(ex_first_val), .ex_second_val(ex_second_val),
    .ex_opcode(ex_opcode), .ex_func(ex_func), .ex_sa(ex_sa),
    .ex_store_data(ex_store_data), .ex_dest(ex_dest),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic        v;
    logic [31:0] a, b;
    logic [5:0]  op, fn;
    logic [4:0]  sa, dest;
    logic        rw, mr, mw;
    logic [31:0] sd;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic exp_t mk(logic v, logic [31:0] a, logic [31:0] b, logic [5:0] op,
                              logic [5:0] fn, logic [4:0] dest, logic rw, logic mr,
                              logic mw, logic [31:0] sd);
    exp_t e;
    e.v = v; e.a = a; e.b = b; e.op = op; e.fn = fn; e.sa = 5'd0; e.dest = dest;
    e.rw = rw; e.mr = mr; e.mw = mw; e.sd = sd;
    return e;
  endfunction

  function automatic logic [31:0] rtype(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_id(input logic v, input logic [31:0] instr,
                          input logic [31:0] rsv, input logic [31:0] rtv);
    dif.id_valid  = v;
    dif.id_instr  = instr;
    dif.id_rs_val = rsv;
    dif.id_rt_val = rtv;
  endtask

  task automatic set_exm(input logic en, input logic mr, input logic [4:0] addr, input logic [31:0] data);
    exm_wr_en = en; exm_mem_read = mr; exm_wr_addr = addr; exm_wr_data = data;
  endtask

  task automatic set_wb(input logic en, input logic [4:0] addr, input logic [31:0] data);
    wb_wr_en = en; wb_wr_addr = addr; wb_wr_data = data;
  endtask

  // Advance one edge, pop the oldest expectation and compare every EX output.
  task automatic step(input string name);
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s scoreboard_empty observed=0 expected=1", name);
    end else begin
      e = q.pop_front();
      chk({name, ".valid"},  32'(ex_valid),      32'(e.v));
      chk({name, ".first"},  ex_first_val,       e.a);
      chk({name, ".second"}, ex_second_val,      e.b);
      chk({name, ".opcode"}, 32'(ex_opcode),     32'(e.op));
      chk({name, ".func"},   32'(ex_func),       32'(e.fn));
      chk({name, ".sa"},     32'(ex_sa),         32'(e.sa));
      chk({name, ".dest"},   32'(ex_dest),       32'(e.dest));
      chk({name, ".rw"},     32'(ex_reg_write),  32'(e.rw));
      chk({name, ".mr"},     32'(ex_mem_read),   32'(e.mr));
      chk({name, ".mw"},     32'(ex_mem_write),  32'(e.mw));
      chk({name, ".store"},  ex_store_data,      e.sd);
      $display("step %-12s valid=%0d first=%h second=%h dest=%0d stall_cnt=%0d",
               name, ex_valid, ex_first_val, ex_second_val, ex_dest, stall_cnt);
    end
  endtask

  exp_t bub;
  logic [31:0] add544;

  initial begin
    bub = mk(1'b0, 32'd0, 32'd0, 6'd0, 6'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    add544 = rtype(5'd4, 5'd4, 5'd5, 6'h20);
    flush = 1'b0;
    set_exm(1'b0, 1'b0, 5'd0, 32'd0);
    set_wb(1'b0, 5'd0, 32'd0);
    drive_id(1'b0, 32'd0, 32'd0, 32'd0);

    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    chk("por.valid", 32'(ex_valid), 32'd0);
    chk("por.cnt", 32'(stall_cnt), 32'd0);
    chk("por.ready", 32'(dif.id_ready), 32'd1);
    rst_n = 1'b1;

    // Mid-stream traffic: lw, a dependent add that stalls once, another lw
    drive_id(1'b1, itype(6'h23, 5'd0, 5'd4, 16'd8), 32'd0, 32'd0);
    q.push_back(mk(1'b1, 32'd0, 32'd8, 6'h23, 6'd0, 5'd4, 1'b1, 1'b1, 1'b0, 32'd0));
    step("pre_lw");
    drive_id(1'b1, add544, 32'd0, 32'd0);
    #1 chk("pre_stall.ready", 32'(dif.id_ready), 32'd0);
    q.push_back(bub);
    step("pre_stall");
    chk("pre_stall.cnt", 32'(stall_cnt), 32'd1);
    drive_id(1'b1, itype(6'h23, 5'd0, 5'd4, 16'd8), 32'd0, 32'd0);
    q.push_back(mk(1'b1, 32'd0, 32'd8, 6'h23, 6'd0, 5'd4, 1'b1, 1'b1, 1'b0, 32'd0));
    step("pre_lw2");

    // Asynchronous reset in the middle of a cycle
    #2 rst_n = 1'b0;
    #1;
    chk("rst.valid", 32'(ex_valid), 32'd0);
    chk("rst.second", ex_second_val, 32'd0);
    chk("rst.dest", 32'(ex_dest), 32'd0);
    chk("rst.mr", 32'(ex_mem_read), 32'd0);
    chk("rst.opcode", 32'(ex_opcode), 32'd0);
    chk("rst.cnt", 32'(stall_cnt), 32'd0);
    chk("rst.ready", 32'(dif.id_ready), 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // First edge after release captures addi $1,$0,5
    drive_id(1'b1, itype(6'h08, 5'd0, 5'd1, 16'd5), 32'd0, 32'd0);
    q.push_back(mk(1'b1, 32'd0, 32'd5, 6'h08, 6'd0, 5'd1, 1'b1, 1'b0, 1'b0, 32'd0));
    step("addi_post");

    // Forwarding: exm supplies rs, wb supplies rt
    drive_id(1'b1, rtype(5'd1, 5'd2, 5'd3, 6'h20), 32'd1, 32'd2);
    set_exm(1'b1, 1'b0, 5'd1, 32'd10);
    set_wb(1'b1, 5'd2, 32'd20);
    q.push_back(mk(1'b1, 32'd10, 32'd20, 6'h00, 6'h20, 5'd3, 1'b1, 1'b0, 1'b0, 32'd0));
    step("fwd_exm_wb");
    // exm and wb both write $2: exm wins
    set_exm(1'b1, 1'b0, 5'd2, 32'd30);
    q.push_back(mk(1'b1, 32'd1, 32'd30, 6'h00, 6'h20, 5'd3, 1'b1, 1'b0, 1'b0, 32'd0));
    step("fwd_prio");
    // Writes to $0 never forward
    drive_id(1'b1, rtype(5'd0, 5'd2, 5'd3, 6'h20), 32'h99, 32'h22);
    set_exm(1'b1, 1'b0, 5'd0, 32'h77);
    set_wb(1'b1, 5'd0, 32'h88);
    q.push_back(mk(1'b1, 32'd0, 32'h22, 6'h00, 6'h20, 5'd3, 1'b1, 1'b0, 1'b0, 32'd0));
    step("fwd_zero");
    set_exm(1'b0, 1'b0, 5'd0, 32'd0);
    set_wb(1'b0, 5'd0, 32'd0);

    // Idle cycle
    drive_id(1'b0, 32'd0, 32'd0, 32'd0);
    q.push_back(bub);
    step("idle");

    // Load-use at distance 1: two bubbles, then add with wb load data
    drive_id(1'b1, itype(6'h23, 5'd0, 5'd4, 16'd8), 32'd0, 32'd0);
    q.push_back(mk(1'b1, 32'd0, 32'd8, 6'h23, 6'd0, 5'd4, 1'b1, 1'b1, 1'b0, 32'd0));
    step("lu_lw");
    drive_id(1'b1, add544, 32'h11, 32'h11);
    #1 chk("lu_s1.ready", 32'(dif.id_ready), 32'd0);
    q.push_back(bub);
    step("lu_stall1");
    chk("lu_s1.cnt", 32'(stall_cnt), 32'd1);
    set_exm(1'b1, 1'b1, 5'd4, 32'hDEAD);
    #1 chk("lu_s2.ready", 32'(dif.id_ready), 32'd0);
    q.push_back(bub);
    step("lu_stall2");
    chk("lu_s2.cnt", 32'(stall_cnt), 32'd2);
    set_exm(1'b0, 1'b0, 5'd0, 32'd0);
    set_wb(1'b1, 5'd4, 32'h55);
    #1 chk("lu_go.ready", 32'(dif.id_ready), 32'd1);
    q.push_back(mk(1'b1, 32'h55, 32'h55, 6'h00, 6'h20, 5'd5, 1'b1, 1'b0, 1'b0, 32'd0));
    step("lu_add");
    chk("lu_add.cnt", 32'(stall_cnt), 32'd2);
    set_wb(1'b0, 5'd0, 32'd0);

    // Flush during a stall
    set_exm(1'b1, 1'b1, 5'd4, 32'd0);
    drive_id(1'b1, add544, 32'd0, 32'd0);
    q.push_back(bub);
    step("fl_stall");
    chk("fl_stall.cnt", 32'(stall_cnt), 32'd3);
    flush = 1'b1;
    #1 chk("fl.ready", 32'(dif.id_ready), 32'd1);
    q.push_back(bub);
    step("flush");
    chk("flush.cnt", 32'(stall_cnt), 32'd3);
    flush = 1'b0;
    set_exm(1'b0, 1'b0, 5'd0, 32'd0);

    // Immediate extension and store data
    drive_id(1'b1, itype(6'h0C, 5'd0, 5'd6, 16'h8000), 32'd0, 32'd0);
    q.push_back(mk(1'b1, 32'd0, 32'h0000_8000, 6'h0C, 6'd0, 5'd6, 1'b1, 1'b0, 1'b0, 32'd0));
    step("andi");
    drive_id(1'b1, itype(6'h08, 5'd0, 5'd7, 16'h8000), 32'd0, 32'd0);
    q.push_back(mk(1'b1, 32'd0, 32'hFFFF_8000, 6'h08, 6'd0, 5'd7, 1'b1, 1'b0, 1'b0, 32'd0));
    step("addi_neg");
    drive_id(1'b1, itype(6'h2B, 5'd1, 5'd2, 16'd4), 32'h100, 32'h9);
    set_exm(1'b1, 1'b0, 5'd2, 32'h1234);
    q.push_back(mk(1'b1, 32'h100, 32'd4, 6'h2B, 6'd0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h1234));
    step("sw");
    set_exm(1'b0, 1'b0, 5'd0, 32'd0);

    // Branch and jump operands
    drive_id(1'b1, itype(6'h04, 5'd1, 5'd2, 16'd3), 32'hA, 32'hB);
    q.push_back(mk(1'b1, 32'hA, 32'hB, 6'h04, 6'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0));
    step("beq");
    drive_id(1'b1, {6'h02, 26'h0C2_0421}, 32'hA, 32'hB);
    q.push_back(mk(1'b1, 32'd0, 32'd0, 6'h02, 6'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0));
    step("j");

    // Saturation: a load in EX/MEM blocks rs for 65540 cycles
    set_exm(1'b1, 1'b1, 5'd4, 32'd0);
    drive_id(1'b1, add544, 32'd0, 32'd0);
    repeat (65540) @(posedge clk);
    #1;
    chk("sat.cnt", 32'(stall_cnt), 32'h0000_FFFF);
    chk("sat.valid", 32'(ex_valid), 32'd0);
    chk("sat.ready", 32'(dif.id_ready), 32'd0);
    $display("step %-12s stall_cnt=%h", "saturate", stall_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
